// File: rtl/cntr_sched_pkg.sv
// Shared types and constants for the cntr_sched counter scheduler.
package cntr_sched_pkg;

  localparam int CS_W = 4;
  localparam logic [CS_W-1:0] CS_TERM = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } cs_state_e;

  // Index of the set bit; requester count never exceeds 8.
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    oh2idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) oh2idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/cntr_sched_if.sv
// Requester/counter bundle between cntr_sched (slave) and its surroundings (master).
interface cntr_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] start_val;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic              cnt_ld;
  logic [W-1:0]      cnt_d;
  logic [W-1:0]      cnt_q;

  modport slave (
    input  req, start_val, cnt_q,
    output gnt, done, busy, cnt_ld, cnt_d
  );

  modport master (
    output req, start_val, cnt_q,
    input  gnt, done, busy, cnt_ld, cnt_d
  );
endinterface

// File: rtl/cntr_sched_rr_arb.sv
// Combinational round-robin picker; CNTR_SCHED_FIXED_PRIO_EN pins the search base to index 0.
module cntr_sched_rr_arb #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_win,
  output logic            o_valid
);

  logic [PW-1:0] w_base;

`ifdef CNTR_SCHED_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;
  assign w_base = '0;
`else
  assign w_base = i_ptr;
`endif

  // Scan upward from the base, wrapping; the first asserted request wins.
  always_comb begin
    int idx;
    o_win   = '0;
    o_valid = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(w_base) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!o_valid && i_req[idx]) begin
        o_win[idx] = 1'b1;
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cntr_sched.sv
// Shares one external loadable up-counter among NREQ requesters.
// Build option: CNTR_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module cntr_sched
  import cntr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = CS_W
) (
  input logic         clk,
  input logic         rst,
  cntr_sched_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [W-1:0] TERM = {W{1'b1}};

  cs_state_e       r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_cnt_ld, w_cnt_ld_nxt;
  logic [W-1:0]    r_cnt_d, w_cnt_d_nxt;
  logic [NREQ-1:0] w_win;
  logic            w_valid;
  logic [PW-1:0]   w_ptr;
  logic [2:0]      w_win_idx;

  cntr_sched_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .i_req  (bus.req),
    .i_ptr  (w_ptr),
    .o_win  (w_win),
    .o_valid(w_valid)
  );

  assign w_win_idx = oh2idx(8'(w_win));

`ifdef CNTR_SCHED_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [PW-1:0] r_ptr;
  logic [2:0]    w_gnt_idx;

  assign w_gnt_idx = oh2idx(8'(r_gnt));

  // Next search starts just past the requester that has finished.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (r_state == DONE) begin
      r_ptr <= (int'(w_gnt_idx) == NREQ - 1) ? '0 : PW'(w_gnt_idx + 3'd1);
    end
  end

  assign w_ptr = r_ptr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_cnt_ld <= 1'b0;
      r_cnt_d  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
      r_cnt_ld <= w_cnt_ld_nxt;
      r_cnt_d  <= w_cnt_d_nxt;
    end
  end

  // The load value is captured at grant time, so later start_val changes cannot disturb it.
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_done_nxt   = '0;
    w_busy_nxt   = r_busy;
    w_cnt_ld_nxt = 1'b0;
    w_cnt_d_nxt  = r_cnt_d;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_gnt_nxt    = w_win;
          w_cnt_d_nxt  = bus.start_val[int'(w_win_idx)*W +: W];
          w_cnt_ld_nxt = 1'b1;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = LOAD;
        end
      end
      LOAD: w_state_nxt = RUN;
      RUN: begin
        if (bus.cnt_q == TERM) begin
          w_done_nxt  = r_gnt;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.gnt    = r_gnt;
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;
  assign bus.cnt_ld = r_cnt_ld;
  assign bus.cnt_d  = r_cnt_d;

endmodule

// File: doc/cntr_sched.md
Name: cntr_sched

Overview:
- Scheduler that shares one 4-bit loadable up-counter (ports ld, d, q; increments every cycle when not loading) among NREQ requesters.
- Each requester asks for an interval by presenting a start value. The scheduler arbitrates, loads the counter, waits for terminal count and pulses done to the winner.
- Sits between requester logic and the single shared counter instance; it is the only driver of the counter's ld and d.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 4, counter width; terminal count TERM = all ones (4'hF)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- req  input  NREQ  level request per requester, held until done
- start_val  input  NREQ*W  start value per requester; slice i = bits [i*W +: W]; stable while req[i] high
- gnt  output  NREQ  one-hot grant, registered
- done  output  NREQ  one-cycle completion pulse to the granted requester
- busy  output  1  high in any state except IDLE
- cnt_ld  output  1  load strobe to the shared counter
- cnt_d  output  W  load value to the shared counter
- cnt_q  input  W  counter output q

Behaviour:
- Reset (rst=0, async): state=IDLE; gnt, done, busy, cnt_ld, cnt_d all 0; round-robin pointer = 0 (index 0 highest priority).
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered.
- IDLE:
  - If any req is high, pick the winner round-robin, starting from the index after the last grant.
  - Register gnt=onehot(winner), cnt_d=start_val[winner], cnt_ld=1, busy=1; go to LOAD.
  - Otherwise stay in IDLE with cnt_ld=0.
- LOAD (1 cycle): counter loads on this edge. Next cycle cnt_ld=0; go to RUN.
- RUN:
  - The counter increments each cycle.
  - When cnt_q==TERM, register done=gnt and go to DONE.
  - Otherwise stay in RUN.
- DONE (1 cycle): done pulse is visible. Next cycle: done=0, gnt=0, busy=0, pointer = winner+1 mod NREQ; go to IDLE.
- Latency, with req seen in IDLE at cycle 0 and start value s: LOAD at 1, RUN at 2..17-s, done high at cycle 18-s. Example: s=15 gives done at 3; s=0 gives done at 18.
- Requester handshake: the requester must drop req on the edge that ends its done cycle. If req is still high in the next IDLE cycle, it is treated as a new request.
- req[winner] dropping during LOAD/RUN is ignored; the interval completes and done still pulses. Aborts are not supported.
- start_val changes after LOAD are ignored, because cnt_d is latched in IDLE.
- Counter wrap: never observed, since the FSM leaves RUN at TERM.
- Requests from non-granted requesters while busy: held pending and served in later IDLE cycles.
- Reset mid-operation: immediate return to reset values; no done is issued for the aborted interval.

Optional Feature:
- Macro: CNTR_SCHED_FIXED_PRIO_EN.
- Defined: the round-robin pointer is removed and the lowest asserted index always wins in IDLE.
- Undefined (default): round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Package cntr_sched_pkg:
  - state enum (IDLE, LOAD, RUN, DONE)
  - default W, derived TERM constant
  - function onehot-to-index
- Sub-module cntr_sched_rr_arb: combinational round-robin picker with inputs req and pointer, outputs one-hot win and valid. Under CNTR_SCHED_FIXED_PRIO_EN the pointer is tied to 0.
- The shared counter is instantiated one level up, not inside cntr_sched.

Test Plan:
- Reset: hold rst=0 with random req -> gnt=0, done=0, busy=0, cnt_ld=0; release, no req -> stays IDLE.
- Single requester: req[2]=1, start_val[2]=12, counter attached -> gnt=4'b0100 at cycle 1, cnt_ld=1 and cnt_d=12 at cycle 1, done[2] pulse at cycle 6, busy low at cycle 7.
- Boundary start values: s=15 -> done at cycle 3; s=0 -> done at cycle 18 with cnt_q stepping 0..15 and no wrap.
- Contention: req=4'b1111, all s=14, each requester drops req after its done -> grant order 0,1,2,3 under round-robin. With CNTR_SCHED_FIXED_PRIO_EN and all requesters re-requesting immediately -> index 0 is re-granted every time.
- Reset mid-RUN: assert rst=0 during RUN with cnt_q=9 -> outputs clear asynchronously, no done pulse; after release, pending req is regranted starting from pointer 0.
- Protocol: req drops during RUN -> done still pulses at the computed cycle; start_val changes after LOAD -> no effect on cnt_d.
